alu_md_unit: RTL
================

Name: alu_md_unit

Overview:
- Parametrised successor to the pipeline's combinational EX-stage ALU.
- Registered single-cycle ALU path with signed and unsigned compares and real zero/overflow flags.
- Adds an iterative multiply/divide engine that writes the HI/LO registers, with busy/done handshake to the hazard unit.
- Sits in the EX stage. The hazard unit stalls ID/EX while busy=1.

Parameters:
- WIDTH, 32, datapath width in bits (>=8).
- EN_MULDIV, 1, when 0 the mult/div engine is removed and codes 1000-1011 behave as nop.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation present on alu_ctl/in1/in2 this cycle
- alu_ctl  in  4  operation code
- in1  in  WIDTH  operand A (rs)
- in2  in  WIDTH  operand B (rt/imm)
- out_valid  out  1  one-cycle pulse, out/zero/overflow valid
- out  out  WIDTH  registered result
- zero  out  1  out == 0, registered with out
- overflow  out  1  signed overflow of add/sub, registered with out
- busy  out  1  mult/div engine running; no new op accepted
- md_done  out  1  one-cycle pulse when HI/LO updated
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst=1 at posedge): out=0, zero=0, overflow=0, out_valid=0, busy=0, md_done=0, hi=0, lo=0. Any in-progress mult/div is aborted with no HI/LO write. rst has priority over in_valid.
- Accept: an op is accepted when in_valid=1 and busy=0. While busy=1, in_valid is ignored (no out_valid, no state change), and the upstream stage holds.
- Simple ops (accepted at edge T): out, zero and overflow update at edge T, and out_valid=1 for exactly one cycle after T. Latency is 1 cycle, back-to-back issue is allowed every cycle.
- Simple op codes:
  - 0000 and
  - 0001 or
  - 0010 add (modulo 2^WIDTH)
  - 0110 sub (modulo 2^WIDTH)
  - 0111 slt (signed, out = 1 or 0)
  - 0100 sltu (unsigned)
  - 1100 nor
  - 1111 xor
  - 0101 mfhi (out = hi)
  - 1101 mflo (out = lo)
  - 0011 nop (out = 0)
  - 1110 reserved (out = 0)
- overflow rules:
  - add: operands share a sign and the result sign differs.
  - sub: operand signs differ and the result sign differs from in1.
  - All other ops: overflow=0. Overflow does not suppress the result.
- Mult/div codes: 1000 mult (signed), 1001 multu, 1010 div (signed), 1011 divu. No out_valid pulse is generated; out, zero and overflow hold their previous values.
- Mult/div state machine: IDLE -> RUN -> IDLE.
  - Accept at edge T: operands are latched and made unsigned (magnitude for signed ops), the result sign is recorded, the counter is loaded with WIDTH, busy=1.
  - RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle.
  - At edge T+WIDTH: hi/lo are written, busy=0, md_done=1 for one cycle. A new op may be accepted at edge T+WIDTH+1.
- Mult result: the 2*WIDTH-bit product; hi = upper half, lo = lower half. Signed mult negates the product when the operand signs differ.
- Div result: lo = quotient truncated toward zero, hi = remainder carrying the dividend's sign.
  - Most-negative / -1: lo = most-negative, hi = 0.
  - Divide by zero (div or divu): lo = all ones, hi = in1. Still takes WIDTH cycles.
- mfhi/mflo issued in the cycle md_done=1 is accepted and returns the new value.
- in1 and in2 are sampled only at accept; changes during RUN have no effect.
- EN_MULDIV=0: busy and md_done are tied 0, and hi/lo stay 0.

Test Plan (WIDTH=32):
- Reset then add 0x7FFFFFFF + 0x00000001 -> next cycle out=0x80000000, overflow=1, zero=0, out_valid for 1 cycle. Then sub 5-5 -> out=0, zero=1, overflow=0.
- slt vs sltu with in1=0xFFFFFFFF, in2=1 -> slt out=1, sltu out=0. Back-to-back issue on consecutive cycles yields out_valid on 2 consecutive cycles.
- mult 0xFFFFFFFE (-2) x 3 -> busy for 32 cycles, md_done at edge T+32, hi=0xFFFFFFFF, lo=0xFFFFFFFA. Then mflo -> out=0xFFFFFFFA. multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 7/0 -> lo=0xFFFFFFFF, hi=7. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- While busy, drive in_valid with add 1+1 on every cycle -> no out_valid until after md_done. The op held at md_done+1 is accepted with 1-cycle latency.
- Assert rst at cycle 10 of a div -> busy=0 next cycle, hi=lo=0, no md_done. A subsequent divu 100/7 -> lo=14, hi=2.

Source files
------------

// File: rtl/alu_md_if.sv
// Operation/result bundle between the EX stage and alu_md_unit.
// Carries the issue handshake, ALU result flags and the HI/LO view.
interface alu_md_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             overflow;
    logic             busy;
    logic             md_done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, alu_ctl, in1, in2,
        input  out_valid, out, zero, overflow,
        input  busy, md_done, hi, lo
    );

    modport slave (
        input  in_valid, alu_ctl, in1, in2,
        output out_valid, out, zero, overflow,
        output busy, md_done, hi, lo
    );
endinterface

// File: rtl/alu_md_unit.sv
// EX-stage registered ALU with an iterative multiply/divide engine.
// HI/LO are written WIDTH cycles after a mult/div is accepted.
module alu_md_unit #(
    parameter int WIDTH     = 32,
    parameter bit EN_MULDIV = 1'b1
) (
    input logic     clk,
    input logic     rst,
    alu_md_if.slave bus
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t state, state_nx;

    logic [3:0]       ctl;
    logic [WIDTH-1:0] a, b;
    logic             busy, last, accept;
    logic             is_md, md_go, alu_go;

    assign ctl    = bus.alu_ctl;
    assign a      = bus.in1;
    assign b      = bus.in2;
    assign is_md  = EN_MULDIV && (ctl[3:2] == 2'b10);
    assign accept = bus.in_valid && !busy;
    assign md_go  = accept && is_md;
    assign alu_go = accept && !is_md;

    // Simple ALU result
    logic [WIDTH-1:0] res, sum, dif;
    logic             ovf;
    logic [WIDTH-1:0] hi_q, lo_q;

    always_comb begin
        sum = a + b;
        dif = a - b;
        res = '0;
        ovf = 1'b0;
        unique case (ctl)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: begin
                res = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1])
                   && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0110: begin
                res = dif;
                ovf = (a[WIDTH-1] != b[WIDTH-1])
                   && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0111: res = WIDTH'($signed(a) < $signed(b));
            4'b0100: res = WIDTH'(a < b);
            4'b1100: res = ~(a | b);
            4'b1111: res = a ^ b;
            4'b0101: res = hi_q;
            4'b1101: res = lo_q;
            default: res = '0;
        endcase
    end

    // Mult/div operand conditioning at accept
    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign sgn   = ~ctl[0];
    assign a_neg = sgn & a[WIDTH-1];
    assign b_neg = sgn & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // acc holds {partial, multiplier} for mult, {rem, quot} for div
    logic [W2-1:0]    acc;
    logic [WIDTH-1:0] opb;
    logic [CW-1:0]    cnt;
    logic             md_div, neg_q, neg_r, dz;

    logic [WIDTH:0]   mul_sum, div_rs, div_df;
    logic [W2-1:0]    mul_nx, div_nx, step_nx, mul_res;
    logic [WIDTH-1:0] q_mag, r_mag, fin_hi, fin_lo;

    always_comb begin
        mul_sum = {1'b0, acc[W2-1:WIDTH]}
                + (acc[0] ? {1'b0, opb} : '0);
        mul_nx  = {mul_sum, acc[WIDTH-1:1]};
        div_rs  = {acc[W2-1:WIDTH], acc[WIDTH-1]};
        div_df  = div_rs - {1'b0, opb};
        div_nx  = div_df[WIDTH]
                ? {div_rs[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                : {div_df[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        step_nx = md_div ? div_nx : mul_nx;
        mul_res = neg_q ? -mul_nx : mul_nx;
        q_mag   = div_nx[WIDTH-1:0];
        r_mag   = div_nx[W2-1:WIDTH];
        if (md_div) begin
            fin_lo = dz ? '1 : (neg_q ? -q_mag : q_mag);
            fin_hi = neg_r ? -r_mag : r_mag;
        end else begin
            fin_lo = mul_res[WIDTH-1:0];
            fin_hi = mul_res[W2-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (md_go) state_nx = S_RUN;
            S_RUN:  if (last)  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        last = busy && (cnt == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            opb    <= '0;
            cnt    <= '0;
            md_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else if (md_go) begin
            acc    <= {{WIDTH{1'b0}}, a_mag};
            opb    <= b_mag;
            cnt    <= CW'(WIDTH);
            md_div <= ctl[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz     <= (b == '0);
        end else if (busy) begin
            acc    <= step_nx;
            cnt    <= cnt - CW'(1);
        end
    end

    logic [WIDTH-1:0] out_q;
    logic             zero_q, ovf_q, ov_q, done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            ov_q   <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            ov_q   <= alu_go;
            done_q <= last;
            if (alu_go) begin
                out_q  <= res;
                zero_q <= (res == '0);
                ovf_q  <= ovf;
            end
            if (last) begin
                hi_q <= fin_hi;
                lo_q <= fin_lo;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ovf_q;
    assign bus.out_valid = ov_q;
    assign bus.busy      = busy;
    assign bus.md_done   = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule
